l2_refill_responder: RTL and testbench

- L2-side responder for the per-thread L1 instruction line buffers in the fine-grained multithreaded core.
- Collects refill, branch and speculative (next-line) requests from NTHREADS L1 buffers and arbitrates among them.
- Fetches one 128-bit line at a time from the backing instruction memory over a req/gnt/rvalid handshake.
- Returns the line with its aligned address and thread ID as a one-cycle response pulse that all L1 buffers observe.

---
 rtl/l2_refill_responder.sv | 158 +++++++++++++++
 tb/tb_l2_refill_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_refill_responder.sv
// rtl/l2_refill_responder.sv - L2-side line refill responder for per-thread L1 instruction buffers
module l2_refill_responder #(
    parameter int NTHREADS = 4,
    parameter int TID_bits = $clog2(NTHREADS),
    parameter int LINE_W   = 128
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NTHREADS-1:0]    req_refill,
    input  logic [NTHREADS-1:0]    br_req,
    input  logic [NTHREADS-1:0]    req_spec,
    input  logic [NTHREADS*32-1:0] req_addr,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [LINE_W-1:0]      mem_rdata,
    output logic [31:0]            l2addr,
    output logic [TID_bits-1:0]    l2_tid,
    output logic [LINE_W-1:0]      l2_line,
    output logic                   l2_valid_rsp,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [TID_bits-1:0]   r_tid;
    logic [TID_bits-1:0]   r_rr_ptr;
    logic [31:0]           r_mem_addr;
    logic                  r_mem_req;
    logic [31:0]           r_l2addr;
    logic [TID_bits-1:0]   r_l2_tid;
    logic [LINE_W-1:0]     r_l2_line;
    logic                  r_l2_valid_rsp;
    logic                  r_busy;
    logic [31:0]           r_last_spec [NTHREADS];
    logic [NTHREADS-1:0]   r_last_spec_valid;

    logic [31:0]           w_dem_line  [NTHREADS];
    logic [31:0]           w_spec_line [NTHREADS];
    logic [NTHREADS-1:0]   w_spec_elig;
    logic [NTHREADS-1:0]   w_cls_vec;
    logic                  w_is_spec;
    logic                  w_found;
    logic [TID_bits-1:0]   w_win;
    logic [TID_bits-1:0]   w_idx;
    logic [31:0]           w_win_line;

    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign l2addr       = r_l2addr;
    assign l2_tid       = r_l2_tid;
    assign l2_line      = r_l2_line;
    assign l2_valid_rsp = r_l2_valid_rsp;
    assign busy         = r_busy;

    // Per-thread candidate lines; a spec request already fetched for the same line is suppressed
    always_comb begin
        for (int t = 0; t < NTHREADS; t++) begin
            w_dem_line[t]  = {req_addr[t*32+4 +: 28], 4'b0000};
            w_spec_line[t] = {req_addr[t*32+4 +: 28] + 28'd1, 4'b0000};
            w_spec_elig[t] = req_spec[t] &
                             ~(r_last_spec_valid[t] && (r_last_spec[t] == w_spec_line[t]));
        end
    end

    // Class priority refill > branch > spec, then round-robin from r_rr_ptr within the class
    always_comb begin
        w_is_spec = 1'b0;
        if (|req_refill) begin
            w_cls_vec = req_refill;
        end else if (|br_req) begin
            w_cls_vec = br_req;
        end else begin
            w_cls_vec = w_spec_elig;
            w_is_spec = 1'b1;
        end
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            w_idx = r_rr_ptr + TID_bits'(i);
            if (!w_found && w_cls_vec[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_win_line = w_is_spec ? w_spec_line[w_win] : w_dem_line[w_win];
    end

    // Transaction FSM: arbitrate, issue to memory, wait for data, pulse the response
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_tid             <= '0;
            r_rr_ptr          <= '0;
            r_mem_addr        <= '0;
            r_mem_req         <= 1'b0;
            r_l2addr          <= '0;
            r_l2_tid          <= '0;
            r_l2_line         <= '0;
            r_l2_valid_rsp    <= 1'b0;
            r_busy            <= 1'b0;
            r_last_spec_valid <= '0;
            for (int t = 0; t < NTHREADS; t++) begin
                r_last_spec[t] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_l2_valid_rsp <= 1'b0;
                    if (w_found) begin
                        r_tid      <= w_win;
                        r_mem_addr <= w_win_line;
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_rr_ptr   <= w_win + TID_bits'(1);
                        if (w_is_spec) begin
                            r_last_spec[w_win]       <= w_win_line;
                            r_last_spec_valid[w_win] <= 1'b1;
                        end else begin
                            r_last_spec_valid[w_win] <= 1'b0;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_l2_line      <= mem_rdata;
                        r_l2addr       <= r_mem_addr;
                        r_l2_tid       <= r_tid;
                        r_l2_valid_rsp <= 1'b1;
                        r_state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_l2_valid_rsp <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_refill_responder.sv
// tb/tb_l2_refill_responder.sv - directed and randomized bench for l2_refill_responder
module tb_l2_refill_responder;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_refill;
    logic [N-1:0]   br_req;
    logic [N-1:0]   req_spec;
    logic [N*32-1:0] req_addr;
    logic           mem_req;
    logic [31:0]    mem_addr;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [127:0]   mem_rdata;
    logic [31:0]    l2addr;
    logic [1:0]     l2_tid;
    logic [127:0]   l2_line;
    logic           l2_valid_rsp;
    logic           busy;

    int checks = 0;
    int errors = 0;

    int          m_rr;
    logic [31:0] m_ls  [N];
    bit          m_lsv [N];

    l2_refill_responder #(.NTHREADS(N), .TID_bits(2), .LINE_W(128)) dut (
        .clock(clock), .reset(reset),
        .req_refill(req_refill), .br_req(br_req), .req_spec(req_spec), .req_addr(req_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .l2addr(l2addr), .l2_tid(l2_tid), .l2_line(l2_line),
        .l2_valid_rsp(l2_valid_rsp), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] thr_addr(input int t);
        return req_addr[t*32 +: 32];
    endfunction

    function automatic logic [31:0] next_line(input logic [31:0] a);
        logic [31:0] base;
        base = a & 32'hFFFF_FFF0;
        return base + 32'h10;
    endfunction

    task automatic model_reset();
        m_rr = 0;
        for (int t = 0; t < N; t++) begin
            m_ls[t]  = '0;
            m_lsv[t] = 1'b0;
        end
    endtask

    // Reference choice: highest non-empty class, then the requester closest to m_rr going upward
    task automatic model_pick(output bit found, output int tid, output logic [31:0] line);
        int best_d;
        bit rq;
        bit sp;
        found = 1'b0;
        tid   = 0;
        line  = '0;
        sp    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (!found) begin
                best_d = N;
                for (int t = 0; t < N; t++) begin
                    if (c == 0)      rq = req_refill[t];
                    else if (c == 1) rq = br_req[t];
                    else             rq = req_spec[t] && !(m_lsv[t] && m_ls[t] == next_line(thr_addr(t)));
                    if (rq && ((t - m_rr + N) % N) < best_d) begin
                        best_d = (t - m_rr + N) % N;
                        tid    = t;
                    end
                end
                if (best_d < N) begin
                    found = 1'b1;
                    sp    = (c == 2);
                    line  = sp ? next_line(thr_addr(tid)) : (thr_addr(tid) & 32'hFFFF_FFF0);
                end
            end
        end
        if (found) begin
            m_rr = (tid + 1) % N;
            if (sp) begin
                m_ls[tid]  = line;
                m_lsv[tid] = 1'b1;
            end else begin
                m_lsv[tid] = 1'b0;
            end
        end
    endtask

    // One transaction from an IDLE-cycle negedge; drop bits clear {spec,br,refill} of the served thread
    task automatic serve(input int gd, input int rd, input bit [2:0] drop);
        bit           found;
        int           tid;
        int           n;
        logic [31:0]  line;
        logic [31:0]  held;
        logic [127:0] data;
        model_pick(found, tid, line);
        if (!found) begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk("idle_mem_req", 128'(mem_req), 128'(0));
                chk("idle_busy", 128'(busy), 128'(0));
            end
            return;
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!mem_req && n < 20);
        chk("mem_req_seen", 128'(mem_req), 128'(1));
        chk("mem_addr", 128'(mem_addr), 128'(line));
        chk("busy_issue", 128'(busy), 128'(1));
        held = mem_addr;
        for (int i = 0; i < gd; i++) begin
            step();
            n++;
            chk("req_hold", 128'(mem_req), 128'(1));
            chk("addr_hold", 128'(mem_addr), 128'(held));
        end
        mem_gnt = 1'b1;
        step();
        n++;
        mem_gnt = 1'b0;
        chk("req_drop", 128'(mem_req), 128'(0));
        chk("busy_wait", 128'(busy), 128'(1));
        for (int i = 0; i < rd; i++) begin
            chk("no_early_rsp", 128'(l2_valid_rsp), 128'(0));
            step();
            n++;
        end
        data       = {$urandom, $urandom, $urandom, $urandom};
        mem_rdata  = data;
        mem_rvalid = 1'b1;
        step();
        n++;
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
        chk("rsp_valid", 128'(l2_valid_rsp), 128'(1));
        chk("l2addr", 128'(l2addr), 128'(line));
        chk("l2_tid", 128'(l2_tid), 128'(tid));
        chk("l2_line", l2_line, data);
        chk("busy_resp", 128'(busy), 128'(1));
        chk("latency", 128'(n), 128'(gd + rd + 3));
        if (drop[0]) req_refill[tid] = 1'b0;
        if (drop[1]) br_req[tid]     = 1'b0;
        if (drop[2]) req_spec[tid]   = 1'b0;
        step();
        chk("rsp_pulse_end", 128'(l2_valid_rsp), 128'(0));
        chk("busy_idle", 128'(busy), 128'(0));
        chk("l2addr_hold", 128'(l2addr), 128'(line));
        chk("l2_line_hold", l2_line, data);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        req_refill = '0;
        br_req     = '0;
        req_spec   = '0;
        req_addr   = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        model_reset();
        repeat (3) step();
        chk("rst_mem_req", 128'(mem_req), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_l2addr", 128'(l2addr), 128'(0));
        chk("rst_l2_tid", 128'(l2_tid), 128'(0));
        chk("rst_l2_line", l2_line, 128'(0));
        chk("rst_valid", 128'(l2_valid_rsp), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        reset = 1'b0;
        step();

        // single refill, tid 1
        req_addr[1*32 +: 32] = 32'h0000_1234;
        req_refill[1] = 1'b1;
        serve(0, 1, 3'b111);

        // class priority: refill t3, branch t2, spec t0
        req_addr[0*32 +: 32] = 32'h0000_2008;
        req_addr[2*32 +: 32] = 32'h0000_3000;
        req_addr[3*32 +: 32] = 32'h0000_4444;
        req_spec[0] = 1'b1;
        br_req[2] = 1'b1;
        req_refill[3] = 1'b1;
        repeat (3) serve(0, 1, 3'b111);

        // bring rr pointer to 2, then all four refills held
        req_refill[1] = 1'b1;
        serve(0, 1, 3'b111);
        for (int t = 0; t < N; t++) req_addr[t*32 +: 32] = 32'h0001_0000 + 32'(t) * 32'h40;
        req_refill = 4'b1111;
        repeat (4) serve(0, 1, 3'b001);

        // spec wrap and dedupe
        req_addr[0*32 +: 32] = 32'hFFFF_FFFC;
        req_spec[0] = 1'b1;
        serve(0, 1, 3'b000);
        serve(0, 1, 3'b000);
        req_refill[0] = 1'b1;
        serve(0, 1, 3'b001);
        serve(0, 1, 3'b100);

        // handshake stall
        req_addr[2*32 +: 32] = 32'hABCD_EF01;
        req_refill[2] = 1'b1;
        serve(3, 5, 3'b111);

        // reset while waiting for data, then stray rvalid
        req_addr[3*32 +: 32] = 32'h0000_7770;
        req_refill[3] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!mem_req && n < 20);
        chk("rst_txn_req", 128'(mem_req), 128'(1));
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rst_txn_wait", 128'(busy), 128'(1));
        reset = 1'b1;
        req_refill = '0;
        step();
        reset = 1'b0;
        mem_rdata = {4{32'hDEAD_BEEF}};
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        model_reset();
        chk("post_rst_valid", 128'(l2_valid_rsp), 128'(0));
        chk("post_rst_busy", 128'(busy), 128'(0));
        chk("post_rst_mem_req", 128'(mem_req), 128'(0));
        chk("post_rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("post_rst_l2addr", 128'(l2addr), 128'(0));
        chk("post_rst_l2_tid", 128'(l2_tid), 128'(0));
        chk("post_rst_l2_line", l2_line, 128'(0));
        step();
        chk("post_rst_valid2", 128'(l2_valid_rsp), 128'(0));
        req_addr[2*32 +: 32] = 32'h0000_5678;
        req_refill[2] = 1'b1;
        serve(0, 1, 3'b111);

        // randomized mix of classes, addresses and memory timing
        for (int it = 0; it < 60; it++) begin
            for (int t = 0; t < N; t++) begin
                if ($urandom_range(0, 3) == 0) req_refill[t] = 1'b1;
                if ($urandom_range(0, 3) == 0) br_req[t]     = 1'b1;
                if ($urandom_range(0, 1) == 0) req_spec[t]   = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       req_addr[t*32 +: 32] = 32'h0000_0104;
                        1:       req_addr[t*32 +: 32] = 32'h0000_01F8;
                        2:       req_addr[t*32 +: 32] = 32'hFFFF_FFF8;
                        default: req_addr[t*32 +: 32] = $urandom;
                    endcase
                end
            end
            serve($urandom_range(0, 3), $urandom_range(0, 4), ($urandom_range(0, 1) == 0) ? 3'b111 : 3'b001);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
